// File: rtl/tabla_verdad_barrido.sv
// Exhaustive truth-table sweeper: drives codes 0..7, lets each settle, samples the
// circuit response, and compares it against an expected table.
module tabla_verdad_barrido #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] esperado,
    input  logic       resultado,
    output logic [2:0] datos,
    output logic [7:0] tabla,
    output logic [3:0] errores,
    output logic       busy,
    output logic       done,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [2:0] datos_q;
    logic [7:0] tabla_q;
    logic [3:0] errores_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;

    logic       mismatch_s;
    logic [7:0] tabla_d;
    logic [3:0] errores_d;

    // Capture and compare values applied at the SAMPLE edge
    always_comb begin
        mismatch_s         = (resultado != esperado[datos_q]);
        errores_d          = errores_q + {3'b000, mismatch_s};
        tabla_d            = tabla_q;
        tabla_d[datos_q]   = resultado;
    end

    // Sweep sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            datos_q   <= 3'd0;
            tabla_q   <= 8'd0;
            errores_q <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        datos_q   <= 3'd0;
                        tabla_q   <= 8'd0;
                        errores_q <= 4'd0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_q     <= 4'd0;
                        state_q   <= HOLD;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    tabla_q   <= tabla_d;
                    errores_q <= errores_d;
                    if (datos_q != 3'd7) begin
                        datos_q <= datos_q + 3'd1;
                        cnt_q   <= 4'd0;
                        state_q <= HOLD;
                    end else begin
                        // Final verdict uses the count including this last code
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (errores_d == 4'd0);
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign datos   = datos_q;
    assign tabla   = tabla_q;
    assign errores = errores_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_tabla_verdad_barrido.sv
// Directed bench: sweeps F=(A&B)|C with several expected tables, restart and reset cases.
module tb_tabla_verdad_barrido;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic [7:0] esperado;
    logic       res1, res2;
    logic [2:0] datos1, datos2;
    logic [7:0] tabla1, tabla2;
    logic [3:0] errores1, errores2;
    logic       busy1, busy2, done1, done2, pass1, pass2;
    logic       sel2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign res1 = (datos1[0] & datos1[1]) | datos1[2];
    assign res2 = (datos2[0] & datos2[1]) | datos2[2];

    tabla_verdad_barrido #(.SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start1), .esperado(esperado), .resultado(res1),
        .datos(datos1), .tabla(tabla1), .errores(errores1),
        .busy(busy1), .done(done1), .pass(pass1)
    );

    tabla_verdad_barrido #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .esperado(esperado), .resultado(res2),
        .datos(datos2), .tabla(tabla2), .errores(errores2),
        .busy(busy2), .done(done2), .pass(pass2)
    );

    logic [2:0] m_datos;
    logic [7:0] m_tabla;
    logic [3:0] m_errores;
    logic       m_busy, m_done, m_pass;
    assign m_datos   = sel2 ? datos2   : datos1;
    assign m_tabla   = sel2 ? tabla2   : tabla1;
    assign m_errores = sel2 ? errores2 : errores1;
    assign m_busy    = sel2 ? busy2    : busy1;
    assign m_done    = sel2 ? done2    : done1;
    assign m_pass    = sel2 ? pass2    : pass1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel2) start2 = v;
        else      start1 = v;
    endtask

    // One sweep on the selected instance; restart_at < 0 means no re-pulse
    task automatic sweep(input logic [7:0] esp, input int restart_at,
                         input logic [3:0] exp_err, input int hold);
        int  k;
        bit  seen;
        k    = 0;
        seen = 0;
        esperado = esp;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        while (k < 8 * hold + 5 && !seen) begin
            if (k < 8 * hold) begin
                check_eq("datos", m_datos, (k / hold));
                check_eq("busy",  m_busy, 1);
                check_eq("done_early", m_done, 0);
            end
            if (k == restart_at)          set_start(1'b1);
            else if (k == restart_at + 1) set_start(1'b0);
            @(negedge clk);
            k++;
            if (m_done) seen = 1;
        end
        set_start(1'b0);
        check_eq("latency", k, 8 * hold);
        check_eq("tabla",   m_tabla, 8'hF8);
        check_eq("errores", m_errores, exp_err);
        check_eq("pass",    m_pass, (exp_err == 4'd0));
        check_eq("busy_fin", m_busy, 0);
        @(negedge clk);
        check_eq("done_pulse", m_done, 0);
        repeat (3) @(negedge clk);
        check_eq("idle_datos",   m_datos, 3'd7);
        check_eq("idle_tabla",   m_tabla, 8'hF8);
        check_eq("idle_errores", m_errores, exp_err);
        check_eq("idle_pass",    m_pass, (exp_err == 4'd0));
    endtask

    initial begin
        int bad;
        sel2     = 1'b0;
        rst      = 1'b1;
        start1   = 1'b1;
        start2   = 1'b1;
        esperado = 8'hF8;
        #1;
        check_eq("rst_datos",   datos1, 0);
        check_eq("rst_tabla",   tabla1, 0);
        check_eq("rst_errores", errores1, 0);
        check_eq("rst_busy",    busy1, 0);
        check_eq("rst_done",    done1, 0);
        check_eq("rst_pass",    pass1, 0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("start_during_rst", busy1 | busy2, 0);

        sweep(8'hF8, -1, 4'd0, 5);
        sweep(8'hF9, -1, 4'd1, 5);
        sweep(8'h07, -1, 4'd8, 5);
        sweep(8'hF8, 10, 4'd0, 5);
        sel2 = 1'b1;
        sweep(8'hF8, -1, 4'd0, 2);
        sel2 = 1'b0;

        // Abort a sweep at cycle 17 while errores is already nonzero
        esperado = 8'h07;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("pre_rst_datos",   datos1, 3);
        check_eq("pre_rst_errores", errores1, 3);
        rst    = 1'b1;
        start1 = 1'b1;
        #1;
        check_eq("arst_datos",   datos1, 0);
        check_eq("arst_errores", errores1, 0);
        check_eq("arst_busy",    busy1, 0);
        check_eq("arst_tabla2",  tabla2, 0);
        check_eq("arst_pass2",   pass2, 0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        start1 = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done1 || busy1) bad++;
        end
        check_eq("no_done_after_abort", bad, 0);
        sweep(8'hF8, -1, 4'd0, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
